// File: rtl/ntt_core_dual.sv
// Negacyclic NTT / INTT core: bit-reversed load with optional phi pre-scale,
// in-place radix-2 butterflies, natural-order output with optional iphi post-scale.
module ntt_core_dual #(
   parameter int unsigned q    = 17,
   parameter int unsigned N    = 8,
   parameter int unsigned logq = 5,
   parameter int unsigned logN = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mode,
   input  logic            in_valid,
   input  logic [logq-1:0] poly_in,
   output logic            in_ready,
   output logic            out_valid,
   output logic [logq-1:0] poly_out,
   input  logic            out_ready,
   input  logic            tw_we,
   input  logic [1:0]      tw_sel,
   input  logic [logN-1:0] tw_addr,
   input  logic [logq-1:0] tw_data,
   output logic            busy
);

   localparam int unsigned PW   = 2 * logq;
   localparam int unsigned CW   = logq + 1;
   localparam int unsigned HALF = N / 2;
   localparam int unsigned PAW  = logN - 1;

   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

   state_t            state, next_state;
   logic [logN-1:0]   cnt;
   logic [logN-1:0]   stage;
   logic [PAW-1:0]    pair;
   logic              mode_r;

   logic [logq-1:0]   c_mem  [N];
   logic [logq-1:0]   phi_t  [N];
   logic [logq-1:0]   w_t    [N];
   logic [logq-1:0]   iw_t   [N];
   logic [logq-1:0]   iphi_t [N];

   logic              load_fire;
   logic              last_bfly;
   logic              load_mode;
   logic [logq-1:0]   load_val;
   logic [logN-1:0]   low_mask, j_ext, idx_a, idx_b, tw_k;
   logic [logq-1:0]   tw_val, bf_v, bf_sum, bf_dif;

   function automatic logic [logN-1:0] bitrev(input logic [logN-1:0] x);
      logic [logN-1:0] r;
      for (int i = 0; i < int'(logN); i++) r[i] = x[int'(logN) - 1 - i];
      return r;
   endfunction

   function automatic logic [logq-1:0] mod_mul(input logic [logq-1:0] x, input logic [logq-1:0] y);
      logic [PW-1:0] p;
      p = PW'(x) * PW'(y);
      return logq'(p % PW'(q));
   endfunction

   function automatic logic [logq-1:0] mod_add(input logic [logq-1:0] x, input logic [logq-1:0] y);
      logic [CW-1:0] s;
      s = CW'(x) + CW'(y);
      if (s >= CW'(q)) s = s - CW'(q);
      return logq'(s);
   endfunction

   function automatic logic [logq-1:0] mod_sub(input logic [logq-1:0] x, input logic [logq-1:0] y);
      logic [CW-1:0] d;
      d = CW'(x) - CW'(y);
      if (x < y) d = d + CW'(q);
      return logq'(d);
   endfunction

   // Butterfly addressing: a = pair with a zero inserted at bit 'stage'
   always_comb begin
      low_mask  = (logN'(1) << stage) - logN'(1);
      j_ext     = logN'(pair);
      idx_a     = ((j_ext & ~low_mask) << 1) | (j_ext & low_mask);
      idx_b     = idx_a | (logN'(1) << stage);
      tw_k      = (idx_a & low_mask) << (logN'(logN - 1) - stage);
      tw_val    = mode_r ? iw_t[tw_k] : w_t[tw_k];
      bf_v      = mod_mul(c_mem[idx_b], tw_val);
      bf_sum    = mod_add(c_mem[idx_a], bf_v);
      bf_dif    = mod_sub(c_mem[idx_a], bf_v);
      load_mode = (cnt == '0) ? mode : mode_r;
      load_val  = load_mode ? poly_in : mod_mul(poly_in, phi_t[cnt]);
      poly_out  = mode_r ? mod_mul(c_mem[cnt], iphi_t[cnt]) : c_mem[cnt];
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_LOAD;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      load_fire  = 1'b0;
      last_bfly  = (stage == logN'(logN - 1)) && (pair == PAW'(HALF - 1));
      case (state)
         S_LOAD: begin
            in_ready  = !tw_we;
            load_fire = in_valid && !tw_we;
            if (load_fire && cnt == logN'(N - 1)) next_state = S_COMPUTE;
         end
         S_COMPUTE: begin
            busy = 1'b1;
            if (last_bfly) next_state = S_OUTPUT;
         end
         S_OUTPUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready && cnt == logN'(N - 1)) next_state = S_LOAD;
         end
         default: next_state = S_LOAD;
      endcase
   end

   // Frame counters; cnt wraps to zero naturally after beat N-1
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         stage  <= '0;
         pair   <= '0;
         mode_r <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (load_fire) begin
                  if (cnt == '0) mode_r <= mode;
                  cnt <= cnt + logN'(1);
               end
            end
            S_COMPUTE: begin
               if (pair == PAW'(HALF - 1)) begin
                  pair  <= '0;
                  stage <= last_bfly ? '0 : stage + logN'(1);
               end else begin
                  pair <= pair + PAW'(1);
               end
            end
            S_OUTPUT: begin
               if (out_ready) cnt <= cnt + logN'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (load_fire) begin
            c_mem[bitrev(cnt)] <= load_val;
         end else if (state == S_COMPUTE) begin
            c_mem[idx_a] <= bf_sum;
            c_mem[idx_b] <= bf_dif;
         end
      end
   end

   // Tables are only writable between frames
   always_ff @(posedge clk) begin
      if (tw_we && state == S_LOAD && cnt == '0) begin
         case (tw_sel)
            2'd0:    phi_t[tw_addr]  <= tw_data;
            2'd1:    w_t[tw_addr]    <= tw_data;
            2'd2:    iw_t[tw_addr]   <= tw_data;
            default: iphi_t[tw_addr] <= tw_data;
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_core_dual.sv
// Directed bench for ntt_core_dual with q=17, N=8, psi=3.
module tb_ntt_core_dual;

   localparam int unsigned Q    = 17;
   localparam int unsigned N    = 8;
   localparam int unsigned LOGQ = 5;
   localparam int unsigned LOGN = 3;

   typedef logic [LOGQ-1:0] vec_t [N];

   logic            clk = 1'b0;
   logic            reset, mode, in_valid, in_ready, out_valid, out_ready, tw_we, busy;
   logic [LOGQ-1:0] poly_in, poly_out, tw_data;
   logic [1:0]      tw_sel;
   logic [LOGN-1:0] tw_addr;

   int checks = 0;
   int errors = 0;

   vec_t delta   = '{1, 0, 0, 0, 0, 0, 0, 0};
   vec_t ones    = '{1, 1, 1, 1, 1, 1, 1, 1};
   vec_t rt_in   = '{3, 16, 0, 7, 1, 1, 12, 5};
   vec_t rt_fwd  = '{0, 13, 5, 16, 1, 13, 7, 3};
   vec_t phi_v   = '{1, 3, 9, 10, 13, 5, 15, 11};
   vec_t w_v     = '{1, 9, 13, 15, 0, 0, 0, 0};
   vec_t iw_v    = '{1, 2, 4, 8, 0, 0, 0, 0};
   vec_t iphi_v  = '{15, 5, 13, 10, 9, 3, 1, 6};

   ntt_core_dual #(.q(Q), .N(N), .logq(LOGQ), .logN(LOGN)) dut (
      .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .poly_in(poly_in),
      .in_ready(in_ready), .out_valid(out_valid), .poly_out(poly_out), .out_ready(out_ready),
      .tw_we(tw_we), .tw_sel(tw_sel), .tw_addr(tw_addr), .tw_data(tw_data), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic load_tables();
      for (int s = 0; s < 4; s++) begin
         for (int a = 0; a < int'(N); a++) begin
            tw_we   = 1'b1;
            tw_sel  = 2'(s);
            tw_addr = LOGN'(a);
            case (s)
               0:       tw_data = phi_v[a];
               1:       tw_data = w_v[a];
               2:       tw_data = iw_v[a];
               default: tw_data = iphi_v[a];
            endcase
            @(negedge clk);
         end
      end
      tw_we = 1'b0;
   endtask

   task automatic send_frame(input vec_t v, input logic m, input int tog);
      for (int i = 0; i < int'(N); i++) begin
         in_valid = 1'b1;
         poly_in  = v[i];
         mode     = (tog >= 0 && i >= tog) ? ~m : m;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_load beat %0d: got %b expected 1", i, in_ready);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      mode     = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL out_valid_timeout: got %b expected 1 within 40 cycles", out_valid);
      end
   endtask

   task automatic recv_frame(input vec_t exp, input string name, input int stall_at);
      logic [LOGQ-1:0] held;
      out_ready = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
         checks++;
         if (out_valid !== 1'b1 || poly_out !== exp[i] || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s beat %0d: got valid=%b data=%0d in_ready=%b expected valid=1 data=%0d in_ready=0",
                     name, i, out_valid, poly_out, in_ready, exp[i]);
         end
         if (i == stall_at) begin
            out_ready = 1'b0;
            held = poly_out;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               checks++;
               if (out_valid !== 1'b1 || poly_out !== held || poly_out !== exp[i] || in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL %s stall %0d: got valid=%b data=%0d in_ready=%b expected valid=1 data=%0d in_ready=0",
                           name, c, out_valid, poly_out, in_ready, exp[i]);
               end
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s end: got in_ready=%b out_valid=%b busy=%b expected 1 0 0",
                  name, in_ready, out_valid, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got in_ready=%b out_valid=%b busy=%b expected 1 0 0",
                  in_ready, out_valid, busy);
      end
      reset = 1'b0;
   endtask

   task automatic test_delta_fwd();
      int cyc;
      send_frame(delta, 1'b0, -1);
      wait_out(cyc);
      checks++;
      if (cyc != 13) begin
         errors++;
         $display("FAIL latency: got %0d cycles expected 13", cyc);
      end
      recv_frame(ones, "delta_fwd", -1);
   endtask

   task automatic test_delta_inv();
      int cyc;
      send_frame(ones, 1'b1, -1);
      wait_out(cyc);
      recv_frame(delta, "delta_inv", -1);
   endtask

   task automatic test_round_trip();
      int cyc;
      send_frame(rt_in, 1'b0, -1);
      wait_out(cyc);
      recv_frame(rt_fwd, "rt_fwd", -1);
      send_frame(rt_fwd, 1'b1, -1);
      wait_out(cyc);
      recv_frame(rt_in, "rt_inv", -1);
   endtask

   task automatic test_backpressure();
      int cyc;
      send_frame(rt_in, 1'b0, -1);
      wait_out(cyc);
      recv_frame(rt_fwd, "backpressure", 3);
   endtask

   task automatic test_reset_compute();
      int cyc;
      send_frame(delta, 1'b0, -1);
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_compute: got busy=%b out_valid=%b expected 1 0", busy, out_valid);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: got in_ready=%b busy=%b out_valid=%b expected 1 0 0",
                  in_ready, busy, out_valid);
      end
      reset = 1'b0;
      send_frame(delta, 1'b0, -1);
      wait_out(cyc);
      recv_frame(ones, "after_reset", -1);
   endtask

   task automatic test_tw_gating();
      int cyc;
      send_frame(delta, 1'b0, -1);
      wait_out(cyc);
      out_ready = 1'b0;
      tw_we     = 1'b1;
      tw_sel    = 2'd0;
      tw_addr   = '0;
      tw_data   = '0;
      @(negedge clk);
      tw_we = 1'b0;
      recv_frame(ones, "tw_during_out", -1);
      send_frame(delta, 1'b0, -1);
      wait_out(cyc);
      recv_frame(ones, "tw_unchanged", -1);
   endtask

   task automatic test_mode_toggle();
      int cyc;
      send_frame(rt_in, 1'b0, 4);
      wait_out(cyc);
      recv_frame(rt_fwd, "mode_toggle", -1);
   endtask

   initial begin
      reset     = 1'b1;
      mode      = 1'b0;
      in_valid  = 1'b0;
      poly_in   = '0;
      out_ready = 1'b1;
      tw_we     = 1'b0;
      tw_sel    = '0;
      tw_addr   = '0;
      tw_data   = '0;
      test_reset();
      load_tables();
      test_delta_fwd();
      test_delta_inv();
      test_round_trip();
      test_backpressure();
      test_reset_compute();
      test_tw_gating();
      test_mode_toggle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ntt_core_dual.md
Name: ntt_core_dual

Overview:
- Parametrised successor to the single-mode inverse transform block. Performs either a forward negacyclic NTT or an inverse negacyclic NTT (INTT) on one N-coefficient polynomial mod q, selected per frame.
- Twiddle/phi tables are runtime-loadable through a write port rather than fixed files.
- Sits in the polynomial-arithmetic datapath between the coefficient streamer and the pointwise multiplier, with ready/valid streaming on both sides.

Parameters:
- q, 17: prime modulus; must satisfy q < 2^logq and q ≡ 1 mod 2N.
- N, 8: polynomial length; power of two, N ≥ 4.
- logq, 5: coefficient width.
- logN, 3: log2(N).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = forward NTT, 1 = inverse NTT; sampled with the first accepted input beat of a frame.
- in_valid  in  1  input coefficient valid.
- poly_in  in  logq  input coefficient, natural order, value < q.
- in_ready  out  1  block accepts input this cycle.
- out_valid  out  1  output coefficient valid.
- poly_out  out  logq  output coefficient, natural order.
- out_ready  in  1  downstream accepts output.
- tw_we  in  1  table write strobe.
- tw_sel  in  2  table select: 0 = phi, 1 = w, 2 = iw, 3 = iphi.
- tw_addr  in  logN  table entry index.
- tw_data  in  logq  table entry value.
- busy  out  1  high in COMPUTE and OUTPUT.

Behaviour:
- Reset: state LOAD; CNT, STAGE, PAIR, mode_r = 0; out_valid = 0, busy = 0, in_ready = 1. Coefficient RAM and tables are not reset.
- Table contents, written by software:
  - phi[i] = psi^i
  - w[k] = psi^(2k)
  - iw[k] = psi^(-2k)
  - iphi[i] = N^-1 · psi^-i mod q
- Table writes:
  - Accepted only in LOAD with CNT == 0; ignored in every other state.
  - in_ready = (state == LOAD) && !tw_we, so a table write and a coefficient beat never occur in the same cycle.
- LOAD:
  - On in_valid && in_ready, write to address bitrev(CNT):
    - mode 0: poly_in · phi[CNT] mod q
    - mode 1: poly_in unchanged
  - mode is latched into mode_r when CNT == 0; changes to mode later in the frame are ignored.
  - After beat N-1: CNT ← 0, go to COMPUTE.
- COMPUTE: one butterfly per cycle, STAGE s = 0..logN-1, PAIR j = 0..N/2-1.
  - Index generation:
    - a = j with a 0 inserted at bit s
    - b = a | (1 << s)
    - k = (a mod 2^s) · 2^(logN-1-s)
  - Butterfly:
    - W = w[k] if mode_r = 0, else iw[k]
    - v = c[b]·W mod q (product width 2·logq)
    - c[a] ← (c[a]+v) mod q
    - c[b] ← (c[a]−v) mod q
    - Reduction is by a single conditional subtract/add of q.
  - After j = N/2-1, STAGE increments. After the last pair of stage logN-1, go to OUTPUT with CNT = 0.
  - Compute latency is exactly logN·N/2 cycles. The last input beat is followed by the first out_valid after logN·N/2 + 1 cycles.
- OUTPUT:
  - out_valid = 1.
  - poly_out, combinational from c[CNT]:
    - mode 0: c[CNT]
    - mode 1: c[CNT]·iphi[CNT] mod q
  - On out_ready, CNT increments. After beat N-1, go to LOAD with CNT = 0.
  - When out_ready = 0, poly_out and out_valid hold stable.
- Reset asserted in any state aborts the frame: back to LOAD at the next edge, and no partial output is emitted.
- No overlap: input is not accepted during COMPUTE or OUTPUT (in_ready = 0).

Test Plan:
- Setup for all scenarios: q=17, N=8, psi=3. Load the tables: phi=[1,3,9,10,13,5,15,11], w[0..3]=[1,9,13,15], iw[0..3]=[1,2,4,8], iphi[i] = 15·6^i mod 17.
- Delta, forward: mode=0, input [1,0,0,0,0,0,0,0] → output [1,1,1,1,1,1,1,1]; first out_valid exactly 13 cycles after the last input beat.
- Delta, inverse: mode=1, input [1,1,1,1,1,1,1,1] → output [1,0,0,0,0,0,0,0].
- Round trip: forward then inverse of [3,16,0,7,1,1,12,5] → output equals the input; covers all wrap-around adds and subtracts.
- Backpressure: deassert out_ready for 5 cycles after beat 2 → poly_out/out_valid stable throughout, all 8 beats delivered in order, in_ready stays 0 until beat 7 is taken.
- Reset and gating:
  - Assert reset in the middle of COMPUTE → next cycle in_ready = 1, busy = 0, out_valid = 0; a following delta frame still yields all ones.
  - tw_we issued during OUTPUT → table unchanged.
  - Toggle mode at input beat 4 → the frame uses the mode latched at beat 0.
